// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter/sequencer for the single-port data RAM.
// Optional build macro DMEM_ARB_M0_PRIO_EN: fixed priority for master 0 instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_m0_req,
  input  logic                i_m0_we,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W/8-1:0] i_m0_wstrb,
  output logic                o_m0_gnt,
  output logic                o_m0_rvalid,
  output logic [DATA_W-1:0]   o_m0_rdata,
  input  logic                i_m1_req,
  input  logic                i_m1_we,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  output logic                o_m1_gnt,
  output logic                o_m1_rvalid,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic                o_s_en,
  output logic                o_s_we,
  output logic [ADDR_W-1:0]   o_s_addr,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  input  logic [DATA_W-1:0]   i_s_rdata,
  output logic                o_busy,
  output logic                o_owner
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
    $fatal(1, "dmem_arbiter: RD_LAT must be in 1..7");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $fatal(1, "dmem_arbiter: DATA_W must be a multiple of 8");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       sel;
  logic       read_done;

`ifdef DMEM_ARB_M0_PRIO_EN
  assign sel = i_m1_req && !i_m0_req;
`else
  logic rr_ptr;
  // On a tie the pointer names the winner; a lone requester always wins.
  assign sel = i_m1_req && (!i_m0_req || rr_ptr);
`endif

  assign read_done = (state == S_WAIT) && (cnt == '0) && !i_rst;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    o_m0_gnt   = 1'b0;
    o_m1_gnt   = 1'b0;
    o_s_en     = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_wdata  = '0;
    o_s_wstrb  = '0;
    case (state)
      S_IDLE: begin
        if (!i_rst && (i_m0_req || i_m1_req)) begin
          o_m0_gnt  = !sel;
          o_m1_gnt  = sel;
          o_s_en    = 1'b1;
          o_s_we    = sel ? i_m1_we    : i_m0_we;
          o_s_addr  = sel ? i_m1_addr  : i_m0_addr;
          o_s_wdata = sel ? i_m1_wdata : i_m0_wdata;
          if (o_s_we) begin
            o_s_wstrb = sel ? i_m1_wstrb : i_m0_wstrb;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 3'(RD_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_next = S_IDLE;
        else           cnt_next   = cnt - 3'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      o_owner <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (o_s_en) o_owner <= sel;
    end
  end

`ifndef DMEM_ARB_M0_PRIO_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       rr_ptr <= 1'b0;
    else if (o_s_en) rr_ptr <= !sel;
  end
`endif

  assign o_busy      = (state == S_WAIT);
  assign o_m0_rvalid = read_done && !o_owner;
  assign o_m1_rvalid = read_done && o_owner;
  assign o_m0_rdata  = o_m0_rvalid ? i_s_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_s_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-count based reference model.
module tb_dmem_arbiter;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq [2];
  logic        mwe  [2];
  logic [31:0] maddr[2];
  logic [31:0] mwd  [2];
  logic [3:0]  mst  [2];
  logic [31:0] s_rdata;

  logic        gnt0, gnt1, rv0, rv1, s_en, s_we, busy, owner;
  logic [31:0] rd0, rd1, s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  int checks = 0;
  int errors = 0;

  // Reference model state: time-based view of one outstanding read.
  int   cyc = 0;
  bit   rd_pend = 0;
  int   rd_due = 0;
  bit   rd_own = 0;
  bit   pref = 0;
  bit   own_m = 0;
  bit   g_last[2];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(mreq[0]), .i_m0_we(mwe[0]), .i_m0_addr(maddr[0]), .i_m0_wdata(mwd[0]),
    .i_m0_wstrb(mst[0]), .o_m0_gnt(gnt0), .o_m0_rvalid(rv0), .o_m0_rdata(rd0),
    .i_m1_req(mreq[1]), .i_m1_we(mwe[1]), .i_m1_addr(maddr[1]), .i_m1_wdata(mwd[1]),
    .i_m1_wstrb(mst[1]), .o_m1_gnt(gnt1), .o_m1_rvalid(rv1), .o_m1_rdata(rd1),
    .o_s_en(s_en), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_wdata(s_wdata),
    .o_s_wstrb(s_wstrb), .i_s_rdata(s_rdata), .o_busy(busy), .o_owner(owner)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_m(input int m, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    mreq[m] = req; mwe[m] = we; maddr[m] = a; mwd[m] = d; mst[m] = s;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit          e_g[2], e_rv[2], e_en, e_we, e_busy, e_own, win;
    logic [31:0] e_addr, e_wd, e_rd[2];
    logic [3:0]  e_st;
    @(negedge clk);
    e_g = '{0, 0}; e_rv = '{0, 0}; e_rd = '{32'h0, 32'h0};
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_st = '0; e_busy = 0; e_own = 0; win = 0;
    if (!rst) begin
      e_busy = rd_pend;
      e_own  = own_m;
      if (rd_pend && cyc == rd_due) begin
        e_rv[rd_own] = 1;
        e_rd[rd_own] = s_rdata;
      end
      if (!rd_pend && (mreq[0] || mreq[1])) begin
`ifdef DMEM_ARB_M0_PRIO_EN
        win = !mreq[0];
`else
        win = (mreq[0] && mreq[1]) ? pref : mreq[1];
`endif
        e_g[win] = 1;
        e_en   = 1;
        e_we   = mwe[win];
        e_addr = maddr[win];
        e_wd   = mwd[win];
        e_st   = mwe[win] ? mst[win] : 4'h0;
      end
    end
    chk("gnt0", gnt0, e_g[0]);
    chk("gnt1", gnt1, e_g[1]);
    chk("s_en", s_en, e_en);
    chk("s_we", s_we, e_we);
    chk("s_addr", s_addr, e_addr);
    chk("s_wdata", s_wdata, e_wd);
    chk("s_wstrb", s_wstrb, e_st);
    chk("rvalid0", rv0, e_rv[0]);
    chk("rvalid1", rv1, e_rv[1]);
    chk("rdata0", rd0, e_rd[0]);
    chk("rdata1", rd1, e_rd[1]);
    chk("busy", busy, e_busy);
    chk("owner", owner, e_own);
    if (rst) begin
      rd_pend = 0; pref = 0; own_m = 0;
    end else begin
      if (rd_pend && cyc == rd_due) rd_pend = 0;
      if (e_en) begin
        pref  = !win;
        own_m = win;
        if (!e_we) begin
          rd_pend = 1; rd_due = cyc + RD_LAT; rd_own = win;
        end
      end
    end
    g_last = e_g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Protocol-following random masters: hold payload until granted.
  task automatic rand_masters();
    for (int m = 0; m < 2; m++) begin
      if (!mreq[m] || g_last[m])
        set_m(m, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst = 1'b1;
    s_rdata = '0;
    g_last = '{0, 0};
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single m0 read with a fixed slave word on the return cycle.
    set_m(0, 1, 0, 32'h100, 0, 4'hF);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    s_rdata = 32'hDEADBEEF;
    repeat (RD_LAT + 1) tick();

    // Back-to-back m1 writes.
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, 1, 32'(4 * i), 32'h10 + 32'(i), 4'hF);
      tick();
    end
    set_m(1, 0, 0, 0, 0, 0);
    tick();

    // Contention straight after reset.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1, 1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      set_m(1, 1, 1, 32'h80 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF);
      tick();
    end
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();

    // m1 write arrives while an m0 read is outstanding; held until granted.
    set_m(0, 1, 0, 32'h200, 0, 0);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 1, 1, 32'h300, 32'h55AA, 4'hF);
    for (int i = 0; i < RD_LAT + 2; i++) begin
      s_rdata = $urandom;
      if (g_last[1]) set_m(1, 0, 0, 0, 0, 0);
      tick();
    end
    set_m(1, 0, 0, 0, 0, 0);

    // Reset one cycle after a read grant abandons the read.
    set_m(0, 1, 0, 32'h400, 0, 0);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (RD_LAT + 1) tick();
    set_m(0, 1, 1, 32'h500, 32'h1, 4'hF);
    set_m(1, 1, 1, 32'h600, 32'h2, 4'hF);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0);
    tick();

    // Partial byte strobe write followed by a read.
    set_m(0, 1, 1, 32'h20, 32'h1234, 4'h3);
    tick();
    set_m(0, 1, 0, 32'h20, 32'hFFFF, 4'hF);
    tick();
    set_m(0, 0, 0, 0, 0, 0);
    repeat (RD_LAT + 1) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_masters();
      s_rdata = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
